// File: rtl/alu_mul_seq.sv
// alu_mul_seq: multi-cycle unsigned multiplier that borrows the shared ALU.
//
// Computes multiplicand * multiplier as a 2*DATA_W-bit product by shift-and-add.
// Each RUN cycle issues one ALU ADD of the running upper partial product and
// either the multiplicand or zero. The ALU carry-out is chained into the shift.
// The ALU operands and output enable are driven only while a multiply is in
// flight. Outside RUN the ALU result bus is released and its value is ignored.
//
// Ports:
//   clk               sole clock, rising edge
//   rst_n             synchronous active-low reset
//   start             multiply request, accepted in IDLE or DONE
//   multiplicand      operand M, captured on an accepted start
//   multiplier        operand Q, captured on an accepted start
//   busy              high while iterating
//   done              one-cycle pulse, product valid
//   product_hi/lo     upper/lower half of the last completed product
//   alu_operand_a/b   ALU operands (zero outside RUN)
//   alu_func          ALU function code, always ADD
//   alu_output_enable ALU tristate enable, high only in RUN
//   alu_result        ALU result bus
//   alu_carry         ALU carry flag

module alu_mul_seq #(
    parameter int unsigned  DATA_W     = 8,
    localparam int unsigned ALU_FUNC_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_W-1:0]     multiplicand,
    input  logic [DATA_W-1:0]     multiplier,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_W-1:0]     product_hi,
    output logic [DATA_W-1:0]     product_lo,
    output logic [DATA_W-1:0]     alu_operand_a,
    output logic [DATA_W-1:0]     alu_operand_b,
    output logic [ALU_FUNC_W-1:0] alu_func,
    output logic                  alu_output_enable,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic                  alu_carry
);

    localparam int unsigned           CntW     = $clog2(DATA_W) + 1;
    localparam logic [CntW-1:0]       CntLast  = CntW'(DATA_W - 1);
    localparam logic [ALU_FUNC_W-1:0] FuncAdd  = '0;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e              state_q;
    logic [DATA_W-1:0]   m_reg_q;
    logic [DATA_W-1:0]   p_hi_q;
    logic [DATA_W-1:0]   p_lo_q;
    logic [CntW-1:0]     cnt_q;
    logic                busy_q;
    logic                done_q;
    logic [DATA_W-1:0]   product_hi_q;
    logic [DATA_W-1:0]   product_lo_q;

    logic                in_run;
    logic [DATA_W-1:0]   p_hi_nxt;
    logic [DATA_W-1:0]   p_lo_nxt;

    assign in_run = (state_q == StRun);

    // {carry, sum, p_lo} shifted right by one; the bit dropped is the
    // multiplier bit consumed this iteration.
    assign {p_hi_nxt, p_lo_nxt} = {alu_carry, alu_result, p_lo_q[DATA_W-1:1]};

    // ALU drive, quiet outside RUN so the shared bus is free for others.
    always_comb begin
        alu_operand_a     = '0;
        alu_operand_b     = '0;
        alu_output_enable = 1'b0;
        if (in_run) begin
            alu_operand_a     = p_hi_q;
            alu_operand_b     = p_lo_q[0] ? m_reg_q : '0;
            alu_output_enable = 1'b1;
        end
    end

    assign alu_func = FuncAdd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            m_reg_q      <= '0;
            p_hi_q       <= '0;
            p_lo_q       <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            product_hi_q <= '0;
            product_lo_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        m_reg_q <= multiplicand;
                        p_hi_q  <= '0;
                        p_lo_q  <= multiplier;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    p_hi_q <= p_hi_nxt;
                    p_lo_q <= p_lo_nxt;
                    cnt_q  <= cnt_q + 1'b1;
                    // Fixed latency: no early exit on zero operands.
                    if (cnt_q == CntLast) begin
                        state_q      <= StDone;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        // Architectural product updates only on the final
                        // shift, so it holds through the next operation.
                        product_hi_q <= p_hi_nxt;
                        product_lo_q <= p_lo_nxt;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign product_hi = product_hi_q;
    assign product_lo = product_lo_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq with an ideal combinational ALU model.
module tb_alu_mul_seq;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] multiplicand;
    logic [W-1:0] multiplier;
    logic         busy;
    logic         done;
    logic [W-1:0] product_hi;
    logic [W-1:0] product_lo;
    logic [W-1:0] alu_operand_a;
    logic [W-1:0] alu_operand_b;
    logic [2:0]   alu_func;
    logic         alu_output_enable;
    logic [W-1:0] alu_result;
    logic         alu_carry;

    logic [W:0]   alu_sum;
    logic [W-1:0] junk_res = '0;
    logic         junk_c = 1'b0;

    always #5 clk = ~clk;

    alu_mul_seq #(.DATA_W(W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .multiplicand      (multiplicand),
        .multiplier        (multiplier),
        .busy              (busy),
        .done              (done),
        .product_hi        (product_hi),
        .product_lo        (product_lo),
        .alu_operand_a     (alu_operand_a),
        .alu_operand_b     (alu_operand_b),
        .alu_func          (alu_func),
        .alu_output_enable (alu_output_enable),
        .alu_result        (alu_result),
        .alu_carry         (alu_carry)
    );

    // Shared ALU: adds when enabled, otherwise the bus carries garbage.
    assign alu_sum    = {1'b0, alu_operand_a} + {1'b0, alu_operand_b};
    assign alu_result = alu_output_enable ? alu_sum[W-1:0] : junk_res;
    assign alu_carry  = alu_output_enable ? alu_sum[W] : junk_c;

    always @(negedge clk) begin
        junk_res = W'($urandom);
        junk_c   = 1'($urandom);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2*W-1:0] prod;
        int             cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   last_exp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: samples 1ns after each rising edge.
    initial begin
        int             busy_run;
        int             oe_run;
        logic [2*W-1:0] hold_prod;
        exp_t           e;
        busy_run  = 0;
        oe_run    = 0;
        hold_prod = '0;
        forever begin
            @(posedge clk);
            #1;
            check("busy_and_done", {31'b0, busy & done}, 32'd0);
            check("oe_tracks_busy", {31'b0, alu_output_enable}, {31'b0, busy});
            check("alu_func_add", {29'b0, alu_func}, 32'd0);
            if (!alu_output_enable)
                check("idle_operands", {16'b0, alu_operand_a, alu_operand_b}, 32'd0);
            if (!rst_n) begin
                check("rst_busy", {31'b0, busy}, 32'd0);
                check("rst_done", {31'b0, done}, 32'd0);
                check("rst_product", {16'b0, product_hi, product_lo}, 32'd0);
                busy_run  = 0;
                oe_run    = 0;
                hold_prod = '0;
            end else begin
                if (busy) busy_run++;
                if (alu_output_enable) oe_run++;
                if (done) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done: got product 0x%0h with nothing outstanding",
                                 {product_hi, product_lo});
                    end else begin
                        e = sb.pop_front();
                        check("product", {16'b0, product_hi, product_lo}, {16'b0, e.prod});
                        check("done_cycle", cyc, e.cyc);
                        check("busy_len", busy_run, W);
                        check("oe_len", oe_run, W);
                        hold_prod = e.prod;
                    end
                    busy_run = 0;
                    oe_run   = 0;
                end else if (!busy) begin
                    check("product_hold", {16'b0, product_hi, product_lo}, {16'b0, hold_prod});
                end
            end
        end
    end

    // Called at a falling edge; start is accepted at the next rising edge.
    task automatic issue(input logic [W-1:0] m, input logic [W-1:0] q);
        exp_t e;
        start        = 1'b1;
        multiplicand = m;
        multiplier   = q;
        e.prod       = (2*W)'(m) * (2*W)'(q);
        e.cyc        = cyc + 1 + W;
        last_exp     = e.cyc;
        sb.push_back(e);
        @(negedge clk);
        start        = 1'b0;
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d outstanding want 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(negedge clk);
        check("reset_state_busy", {31'b0, busy}, 32'd0);
        check("reset_state_oe", {31'b0, alu_output_enable}, 32'd0);
        check("reset_state_product", {16'b0, product_hi, product_lo}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        issue(8'h0F, 8'h0F);
        wait_drain();
        issue(8'hFF, 8'hFF);
        wait_drain();
        issue(8'h00, 8'hAB);
        wait_drain();
        issue(8'hAB, 8'h00);
        wait_drain();

        // A start during RUN must be ignored.
        issue(8'h12, 8'h34);
        repeat (2) @(negedge clk);
        check("ignored_start_busy", {31'b0, busy}, 32'd1);
        start        = 1'b1;
        multiplicand = 8'hFF;
        multiplier   = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        // Reset in the fourth RUN cycle aborts with no done pulse.
        issue(8'hFF, 8'hFF);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_product", {16'b0, product_hi, product_lo}, 32'd0);
        check("abort_oe", {31'b0, alu_output_enable}, 32'd0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);

        // Back-to-back: second start presented during the first DONE cycle.
        issue(8'h10, 8'h10);
        while (cyc < last_exp) @(negedge clk);
        check("b2b_done_high", {31'b0, done}, 32'd1);
        issue(8'h03, 8'h05);
        wait_drain();

        for (int i = 0; i < 24; i++) begin
            issue(W'($urandom), W'($urandom));
            if (($urandom_range(0, 2) == 0) && (i != 23)) begin
                while (cyc < last_exp) @(negedge clk);
            end else begin
                wait_drain();
            end
        end
        wait_drain();
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle unsigned multiply sequencer built around the shared `alu` datapath. It computes a `2*DATA_W`-bit product by shift-and-add, issuing one ALU ADD per iteration and chaining the ALU carry-out into the running partial product. It sits between the instruction control path and the ALU. It drives the ALU operand/function inputs and the ALU tristate output enable only while a multiply is in flight, and leaves the ALU result bus released otherwise.

## Interface
Parameters:
- `DATA_W`, 8, operand width; must match the attached `alu`.
- `ALU_FUNC_W`, 3 (localparam), ALU function code width.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request a multiply; sampled only in IDLE or DONE.
- `multiplicand`  in  DATA_W  operand M; captured on an accepted `start`.
- `multiplier`  in  DATA_W  operand Q; captured on an accepted `start`.
- `busy`  out  1  high while iterating (RUN).
- `done`  out  1  one-cycle pulse; product valid.
- `product_hi`  out  DATA_W  upper half of the product; held until the next accepted `start`.
- `product_lo`  out  DATA_W  lower half of the product; held until the next accepted `start`.
- `alu_operand_a`  out  DATA_W  to `alu.operand_a`.
- `alu_operand_b`  out  DATA_W  to `alu.operand_b`.
- `alu_func`  out  ALU_FUNC_W  to `alu.alu_func`; constant 3'b000 (ADD).
- `alu_output_enable`  out  1  to `alu.output_enable`.
- `alu_result`  in  DATA_W  from the ALU result bus.
- `alu_carry`  in  1  from `alu.carry_flag`.

## Operation
- Internal registers:
  - `m_reg` (DATA_W)
  - `p_hi` (DATA_W)
  - `p_lo` (DATA_W)
  - iteration counter `cnt` ($clog2(DATA_W)+1 bits)
  - state
- States:
  - **IDLE**
    - `start`=1 → load `m_reg`=`multiplicand`, `p_hi`=0, `p_lo`=`multiplier`, `cnt`=0 → RUN.
    - Otherwise stay.
  - **RUN**
    - ALU drive (combinational): `alu_operand_a`=`p_hi`; `alu_operand_b`=`p_lo[0]` ? `m_reg` : 0; `alu_func`=ADD; `alu_output_enable`=1.
    - Each edge: `{p_hi, p_lo}` ← `{alu_carry, alu_result, p_lo} >> 1`, i.e. a (2*DATA_W+1)-bit value shifted right by one.
    - `cnt`++.
    - When `cnt`==DATA_W-1 at the edge → DONE.
  - **DONE**
    - `done`=1; `product_hi`/`product_lo` = `p_hi`/`p_lo`.
    - `start`=1 → reload exactly as in IDLE → RUN (back-to-back).
    - Else → IDLE.
- `start` during RUN is ignored; operands are not re-sampled.
- Outside RUN:
  - `alu_output_enable`=0, so the ALU bus is released.
  - `alu_operand_a`=`alu_operand_b`=0.
  - `alu_func`=000.
- `alu_result`/`alu_carry` are consumed only in RUN. Values outside RUN (including Z/X) must not affect state.
- Arithmetic: unsigned only. A zero addend (`p_lo[0]`=0) forces `alu_carry`=0, so the shift is a pure right shift of `p_hi`. No early exit: latency is fixed regardless of operand values.
- Product registers are architectural: they change only on the shift edges of RUN.

## Timing
- Reset (`rst_n`=0 at an edge):
  - state=IDLE.
  - `busy`=0, `done`=0.
  - `product_hi`=`product_lo`=0, `m_reg`=0, `cnt`=0.
  - `alu_output_enable`=0, ALU operands 0.
- Reset mid-RUN aborts at that edge: no `done` pulse, and product registers are cleared.
- Latency: `start` accepted at edge E0 → `busy`=1 for exactly DATA_W cycles (E0..E0+DATA_W) → `done`=1 for one cycle after edge E0+DATA_W.
  - Total DATA_W+1 cycles from acceptance to `done` (9 for DATA_W=8).
- `busy` and `done` are never high together.
- Throughput with back-to-back `start` in DONE: one product every DATA_W+1 cycles.
- `alu_output_enable` rises on the cycle after E0 and falls on the cycle after the last RUN edge. It is high for exactly DATA_W cycles per operation.
- ALU path is combinational: result and carry are sampled the same cycle the operands are driven, with no wait states.

## Test plan
- `multiplicand`=0x0F, `multiplier`=0x0F, `start` 1 cycle → `done` 9 cycles later, product 0x00E1; `busy` high exactly 8 cycles.
- 0xFF × 0xFF → 0xFE01. Checks carry chaining on every iteration.
- 0x00 × 0xAB and 0xAB × 0x00 → 0x0000. `alu_output_enable` is still high for 8 cycles.
- Start 0x12 × 0x34; pulse `start` with 0xFF × 0xFF during RUN cycle 3 → result 0x03A8; the second request is ignored.
- Start 0xFF × 0xFF; `rst_n`=0 in RUN cycle 4 → next cycle IDLE, `busy`=`done`=0, product 0, `alu_output_enable`=0; no `done` pulse.
- 0x10 × 0x10, then `start` held high in its DONE cycle with 0x03 × 0x05 → first `done` shows 0x0100, second `done` 9 cycles later shows 0x000F; no idle gap between the two operations.
